memsched: RTL and testbench

- Byte-serial scheduler for the single 8-bit RAM/IO port.
- Shares the port between the instruction fetcher (INF, always 4-byte reads) and the data cache (DC, 1/2/4-byte loads and stores).
- Splits each request into byte beats, reassembles read data little-endian, and returns one done pulse per transaction.
- Sits between fetcher/dcache and the top-level mem_* pins.

---
 rtl/memsched_if.sv | 46 ++++
 rtl/memsched.sv | 221 ++++++++++++++++++++++
 tb/tb_memsched.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memsched_if.sv
// memsched_if: request/response and byte-port signals for the memory scheduler.
// The slave modport belongs to the scheduler. The master modport belongs to
// whatever drives the requests and models the RAM/IO port.
interface memsched_if #(
    parameter int ADDR_W = 32
);
    // byte-wide RAM/IO port
    logic              iIO_buffer_full;
    logic [7:0]        iMEM_dt;
    logic              oMEM_rw;
    logic [ADDR_W-1:0] oMEM_addr;
    logic [7:0]        oMEM_dt;

    // instruction fetcher
    logic              iINF_en;
    logic [ADDR_W-1:0] iINF_addr;
    logic              oINF_done;
    logic [31:0]       oINF_inst;

    // data cache
    logic              iDC_en;
    logic              iDC_ls;
    logic [1:0]        iDC_len;
    logic [ADDR_W-1:0] iDC_addr;
    logic [31:0]       iDC_dt;
    logic              oDC_done;
    logic [31:0]       oDC_dt;

    modport slave (
        input  iIO_buffer_full, iMEM_dt,
        input  iINF_en, iINF_addr,
        input  iDC_en, iDC_ls, iDC_len, iDC_addr, iDC_dt,
        output oMEM_rw, oMEM_addr, oMEM_dt,
        output oINF_done, oINF_inst,
        output oDC_done, oDC_dt
    );

    modport master (
        output iIO_buffer_full, iMEM_dt,
        output iINF_en, iINF_addr,
        output iDC_en, iDC_ls, iDC_len, iDC_addr, iDC_dt,
        input  oMEM_rw, oMEM_addr, oMEM_dt,
        input  oINF_done, oINF_inst,
        input  oDC_done, oDC_dt
    );
endinterface

// File: rtl/memsched.sv
// memsched: byte-serial scheduler that shares one 8-bit RAM/IO port between
// the instruction fetcher (4-byte reads) and the data cache (1/2/4-byte loads
// and stores). Each request is split into byte beats. Read data is reassembled
// little-endian, and each transaction returns exactly one done pulse.
// Optional build macro MEMSCHED_RR_EN: round-robin grant on ties. Without it,
// DC always has priority over INF.
module memsched #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    input  logic       clr,
    memsched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_INF, OWN_DC} owner_t;

    state_t            state_reg;
    owner_t            owner_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [1:0]        last_beat_reg;   // number of bytes minus one
    logic [1:0]        beat_reg;        // index of the byte whose address is driven
    logic [1:0]        cap_reg;         // index of the next read byte to capture
    logic              issuing_reg;     // a read address is on the bus this cycle
    logic              vld_reg;         // iMEM_dt holds byte cap_reg this cycle
    logic              rw_reg;
    logic [7:0]        wr_dt_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       rbuf_reg;
    logic              inf_done_reg;
    logic              dc_done_reg;
    logic [31:0]       inf_inst_reg;
    logic [31:0]       dc_dt_reg;
`ifdef MEMSCHED_RR_EN
    logic              last_inf_reg;    // 1 = INF was the most recent grant
`endif

    logic              io_stall;
    logic              inf_req;
    logic              grant_dc;
    logic              grant_inf;
    logic [1:0]        dc_last;
    logic [1:0]        beat_nxt;
    logic [31:0]       rd_word;
    logic [7:0]        wbytes [4];

    genvar gi;

    // An I/O write waits while the UART tx buffer is full. The beat holds.
    assign io_stall = (state_reg == WRITE) && (addr_reg[17:16] == IO_HI) && bus.iIO_buffer_full;
    // A flush at this edge blocks any new INF grant.
    assign inf_req  = bus.iINF_en && !clr;
    // Length code 10 is treated as a word.
    assign dc_last  = (bus.iDC_len == 2'b00) ? 2'd0 :
                      (bus.iDC_len == 2'b01) ? 2'd1 : 2'd3;
    assign beat_nxt = beat_reg + 2'd1;

    // Reassembly word: the byte now on iMEM_dt drops into its little-endian slot.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            assign rd_word[8*gi +: 8] = (cap_reg == 2'(gi)) ? bus.iMEM_dt : rbuf_reg[8*gi +: 8];
            assign wbytes[gi]         = wdata_reg[8*gi +: 8];
        end
    endgenerate

    // Grant selection in IDLE: fixed DC priority, or alternate on a tie.
    always_comb begin
        grant_dc  = 1'b0;
        grant_inf = 1'b0;
`ifdef MEMSCHED_RR_EN
        if (bus.iDC_en && inf_req) begin
            grant_dc  = last_inf_reg;
            grant_inf = !last_inf_reg;
        end else if (bus.iDC_en) begin
            grant_dc  = 1'b1;
        end else if (inf_req) begin
            grant_inf = 1'b1;
        end
`else
        if (bus.iDC_en) begin
            grant_dc  = 1'b1;
        end else if (inf_req) begin
            grant_inf = 1'b1;
        end
`endif
    end

    // Scheduler FSM. A low rdy freezes every register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            owner_reg     <= OWN_NONE;
            base_reg      <= '0;
            addr_reg      <= '0;
            last_beat_reg <= 2'd0;
            beat_reg      <= 2'd0;
            cap_reg       <= 2'd0;
            issuing_reg   <= 1'b0;
            vld_reg       <= 1'b0;
            rw_reg        <= 1'b0;
            wr_dt_reg     <= 8'h00;
            wdata_reg     <= 32'h0;
            rbuf_reg      <= 32'h0;
            inf_done_reg  <= 1'b0;
            dc_done_reg   <= 1'b0;
            inf_inst_reg  <= 32'h0;
            dc_dt_reg     <= 32'h0;
`ifdef MEMSCHED_RR_EN
            last_inf_reg  <= 1'b1;
`endif
        end else if (rdy) begin
            inf_done_reg <= 1'b0;
            dc_done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    rbuf_reg    <= 32'h0;
                    cap_reg     <= 2'd0;
                    beat_reg    <= 2'd0;
                    vld_reg     <= 1'b0;
                    if (grant_dc) begin
                        owner_reg     <= OWN_DC;
                        base_reg      <= bus.iDC_addr;
                        addr_reg      <= bus.iDC_addr;
                        wdata_reg     <= bus.iDC_dt;
                        last_beat_reg <= dc_last;
`ifdef MEMSCHED_RR_EN
                        last_inf_reg  <= 1'b0;
`endif
                        if (bus.iDC_ls) begin
                            state_reg <= WRITE;
                            rw_reg    <= 1'b1;
                            wr_dt_reg <= bus.iDC_dt[7:0];
                        end else begin
                            state_reg   <= READ;
                            issuing_reg <= 1'b1;
                        end
                    end else if (grant_inf) begin
                        owner_reg     <= OWN_INF;
                        base_reg      <= bus.iINF_addr;
                        addr_reg      <= bus.iINF_addr;
                        last_beat_reg <= 2'd3;
                        state_reg     <= READ;
                        issuing_reg   <= 1'b1;
`ifdef MEMSCHED_RR_EN
                        last_inf_reg  <= 1'b1;
`endif
                    end
                end
                READ: begin
                    if (clr && owner_reg == OWN_INF) begin
                        // A flush drops the fetch without a done pulse.
                        state_reg   <= IDLE;
                        owner_reg   <= OWN_NONE;
                        addr_reg    <= '0;
                        issuing_reg <= 1'b0;
                        vld_reg     <= 1'b0;
                    end else begin
                        // The address issued this cycle returns data next cycle.
                        vld_reg <= issuing_reg;
                        if (issuing_reg) begin
                            if (beat_reg == last_beat_reg) begin
                                issuing_reg <= 1'b0;
                                addr_reg    <= '0;
                            end else begin
                                beat_reg <= beat_nxt;
                                addr_reg <= base_reg + ADDR_W'(beat_nxt);
                            end
                        end
                        if (vld_reg) begin
                            rbuf_reg <= rd_word;
                            cap_reg  <= cap_reg + 2'd1;
                            if (cap_reg == last_beat_reg) begin
                                state_reg <= DONE;
                                if (owner_reg == OWN_INF) begin
                                    inf_done_reg <= 1'b1;
                                    inf_inst_reg <= rd_word;
                                end else begin
                                    dc_done_reg <= 1'b1;
                                    dc_dt_reg   <= rd_word;
                                end
                            end
                        end
                    end
                end
                WRITE: begin
                    if (!io_stall) begin
                        if (beat_reg == last_beat_reg) begin
                            state_reg   <= DONE;
                            rw_reg      <= 1'b0;
                            addr_reg    <= '0;
                            wr_dt_reg   <= 8'h00;
                            dc_done_reg <= 1'b1;
                        end else begin
                            beat_reg  <= beat_nxt;
                            addr_reg  <= base_reg + ADDR_W'(beat_nxt);
                            wr_dt_reg <= wbytes[beat_nxt];
                        end
                    end
                end
                DONE: begin
                    // Bubble cycle. Requests seen at this edge are ignored.
                    state_reg <= IDLE;
                    owner_reg <= OWN_NONE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // A paused or stalled cycle must never write. A flush cancels a pending fetch done.
    assign bus.oMEM_rw   = rw_reg && rdy && !io_stall;
    assign bus.oMEM_addr = addr_reg;
    assign bus.oMEM_dt   = wr_dt_reg;
    assign bus.oINF_done = inf_done_reg && rdy && !clr;
    assign bus.oINF_inst = inf_inst_reg;
    assign bus.oDC_done  = dc_done_reg && rdy;
    assign bus.oDC_dt    = dc_dt_reg;
endmodule

// File: tb/tb_memsched.sv
// tb_memsched: directed bench for memsched. A byte RAM model answers the
// port. Expected fetch and load results are queued per requester when the
// request is driven, then popped and compared when the done pulse appears.
module tb_memsched;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic clr;

    memsched_if #(.ADDR_W(32)) bus_i ();

    memsched #(.ADDR_W(32), .IO_HI(2'b11)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .clr (clr),
        .bus (bus_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        has_data;
        logic [31:0] data;
    } dc_exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    logic [7:0]  ram [logic [31:0]];
    wr_t         wlog [$];
    logic [31:0] inf_q [$];
    dc_exp_t     dc_q [$];
    bit          order_q [$];

    int errors = 0;
    int checks = 0;
    int inf_pulses = 0;
    int dc_pulses = 0;

    logic        s_rw, s_idone, s_ddone;
    logic [31:0] s_addr;
    logic [7:0]  s_dt;

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return 8'h00;
    endfunction

    // RAM/IO model: writes land at the edge, and read data follows its address by one cycle.
    always @(posedge clk) begin
        if (bus_i.oMEM_rw === 1'b1) begin
            ram[bus_i.oMEM_addr] = bus_i.oMEM_dt;
            wlog.push_back('{bus_i.oMEM_addr, bus_i.oMEM_dt});
        end
        bus_i.iMEM_dt <= ram_rd(bus_i.oMEM_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Sample the current cycle, score any done pulse, then advance to just after the next edge.
    task automatic cyc();
        logic [31:0] ei;
        dc_exp_t     ed;
        #1;
        s_rw    = bus_i.oMEM_rw;
        s_addr  = bus_i.oMEM_addr;
        s_dt    = bus_i.oMEM_dt;
        s_idone = bus_i.oINF_done;
        s_ddone = bus_i.oDC_done;
        if (s_idone) begin
            inf_pulses++;
            order_q.push_back(1'b1);
            if (inf_q.size() > 0) begin
                ei = inf_q.pop_front();
                chk("inf_data", bus_i.oINF_inst, ei);
            end else begin
                chk("inf_extra_done", {31'b0, s_idone}, 32'd0);
            end
            bus_i.iINF_en = 1'b0;
        end
        if (s_ddone) begin
            dc_pulses++;
            order_q.push_back(1'b0);
            if (dc_q.size() > 0) begin
                ed = dc_q.pop_front();
                if (ed.has_data) chk("dc_data", bus_i.oDC_dt, ed.data);
            end else begin
                chk("dc_extra_done", {31'b0, s_ddone}, 32'd0);
            end
            bus_i.iDC_en = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dc(input int max_cyc);
        int start;
        int n;
        start = dc_pulses;
        n = 0;
        while (dc_pulses == start && n < max_cyc) begin
            cyc();
            n++;
        end
        chk("dc_done_wait", 32'(dc_pulses - start), 32'd1);
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((inf_q.size() + dc_q.size()) != 0 && n < max_cyc) begin
            cyc();
            n++;
        end
        chk("drain_pending", 32'(inf_q.size() + dc_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst = 1'b1;
        rdy = 1'b1;
        clr = 1'b0;
        bus_i.iIO_buffer_full = 1'b0;
        bus_i.iINF_en   = 1'b0;
        bus_i.iINF_addr = 32'h0;
        bus_i.iDC_en    = 1'b0;
        bus_i.iDC_ls    = 1'b0;
        bus_i.iDC_len   = 2'b00;
        bus_i.iDC_addr  = 32'h0;
        bus_i.iDC_dt    = 32'h0;
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
        ram[32'h201] = 8'hAB; ram[32'h202] = 8'hCD;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rw", {31'b0, bus_i.oMEM_rw}, 32'd0);
        chk("reset_addr", bus_i.oMEM_addr, 32'd0);
        chk("reset_dt", {24'b0, bus_i.oMEM_dt}, 32'd0);
        chk("reset_done", {30'b0, bus_i.oINF_done, bus_i.oDC_done}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Word fetch from 0x100.
        bus_i.iINF_addr = 32'h100;
        bus_i.iINF_en   = 1'b1;
        inf_q.push_back(32'h00000513);
        cyc();
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("fetch_addr%0d", i), s_addr, 32'h100 + 32'(i));
            chk($sformatf("fetch_rw%0d", i), {31'b0, s_rw}, 32'd0);
        end
        cyc();
        chk("fetch_early_done", {31'b0, s_idone}, 32'd0);
        cyc();
        chk("fetch_done", {31'b0, s_idone}, 32'd1);
        cyc();
        chk("fetch_one_pulse", {31'b0, s_idone}, 32'd0);
        chk("fetch_inst_hold", bus_i.oINF_inst, 32'h00000513);

        // Half load from 0x201, which is unaligned.
        bus_i.iDC_ls   = 1'b0;
        bus_i.iDC_len  = 2'b01;
        bus_i.iDC_addr = 32'h201;
        bus_i.iDC_en   = 1'b1;
        dc_q.push_back('{1'b1, 32'h0000CDAB});
        p0 = dc_pulses;
        cyc();
        cyc();
        chk("half_addr0", s_addr, 32'h201);
        cyc();
        chk("half_addr1", s_addr, 32'h202);
        cyc();
        chk("half_idle_addr", s_addr, 32'h0);
        chk("half_early_done", {31'b0, s_ddone}, 32'd0);
        cyc();
        chk("half_done", {31'b0, s_ddone}, 32'd1);
        cyc();
        cyc();
        chk("half_pulses", 32'(dc_pulses - p0), 32'd1);

        // Byte store to I/O while the tx buffer is full for three cycles.
        bus_i.iIO_buffer_full = 1'b1;
        bus_i.iDC_ls   = 1'b1;
        bus_i.iDC_len  = 2'b00;
        bus_i.iDC_addr = 32'h30000;
        bus_i.iDC_dt   = 32'h00000041;
        bus_i.iDC_en   = 1'b1;
        dc_q.push_back('{1'b0, 32'h0});
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("io_stall_rw%0d", i), {31'b0, s_rw}, 32'd0);
            chk($sformatf("io_stall_addr%0d", i), s_addr, 32'h30000);
        end
        bus_i.iIO_buffer_full = 1'b0;
        cyc();
        chk("io_wr_rw", {31'b0, s_rw}, 32'd1);
        chk("io_wr_addr", s_addr, 32'h30000);
        chk("io_wr_dt", {24'b0, s_dt}, 32'h41);
        cyc();
        chk("io_done", {31'b0, s_ddone}, 32'd1);
        cyc();
        chk("io_ram", {24'b0, ram_rd(32'h30000)}, 32'h41);

        // Reset in the middle of a fetch returns to idle at once.
        bus_i.iINF_addr = 32'h100;
        bus_i.iINF_en   = 1'b1;
        cyc();
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("rst_mid_addr", bus_i.oMEM_addr, 32'h0);
        chk("rst_mid_inst", bus_i.oINF_inst, 32'h0);
        chk("rst_mid_dcdt", bus_i.oDC_dt, 32'h0);
        bus_i.iINF_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();

        // Contention: both requests rise together, then DC re-requests right after its done.
        order_q.delete();
        bus_i.iINF_addr = 32'h100;
        bus_i.iINF_en   = 1'b1;
        bus_i.iDC_ls    = 1'b0;
        bus_i.iDC_len   = 2'b00;
        bus_i.iDC_addr  = 32'h202;
        bus_i.iDC_en    = 1'b1;
        inf_q.push_back(32'h00000513);
        dc_q.push_back('{1'b1, 32'h000000CD});
        wait_dc(20);
        bus_i.iDC_addr = 32'h100;
        bus_i.iDC_en   = 1'b1;
        dc_q.push_back('{1'b1, 32'h00000013});
        drain(40);
        chk("grant_count", 32'(order_q.size()), 32'd3);
        if (order_q.size() >= 3) begin
`ifdef MEMSCHED_RR_EN
            chk("grant_order", {29'b0, order_q[0], order_q[1], order_q[2]}, 32'b010);
`else
            chk("grant_order", {29'b0, order_q[0], order_q[1], order_q[2]}, 32'b001);
`endif
        end
        cyc();

        // Flush after byte 1 of a fetch. A DC store follows at once.
        p0 = inf_pulses;
        bus_i.iINF_addr = 32'h100;
        bus_i.iINF_en   = 1'b1;
        cyc();
        cyc();
        chk("flush_b0", s_addr, 32'h100);
        cyc();
        chk("flush_b1", s_addr, 32'h101);
        clr = 1'b1;
        bus_i.iINF_en  = 1'b0;
        bus_i.iDC_ls   = 1'b1;
        bus_i.iDC_len  = 2'b00;
        bus_i.iDC_addr = 32'h300;
        bus_i.iDC_dt   = 32'h0000005A;
        bus_i.iDC_en   = 1'b1;
        dc_q.push_back('{1'b0, 32'h0});
        cyc();
        clr = 1'b0;
        cyc();
        chk("flush_addr0", s_addr, 32'h0);
        chk("flush_rw0", {31'b0, s_rw}, 32'd0);
        cyc();
        chk("flush_st_rw", {31'b0, s_rw}, 32'd1);
        chk("flush_st_addr", s_addr, 32'h300);
        chk("flush_st_dt", {24'b0, s_dt}, 32'h5A);
        cyc();
        chk("flush_st_done", {31'b0, s_ddone}, 32'd1);
        cyc();
        chk("flush_no_inf_done", 32'(inf_pulses - p0), 32'd0);

        // Pause for four cycles while byte 2 of a word store is on the bus.
        wlog.delete();
        p0 = dc_pulses;
        bus_i.iDC_ls   = 1'b1;
        bus_i.iDC_len  = 2'b11;
        bus_i.iDC_addr = 32'h400;
        bus_i.iDC_dt   = 32'h44332211;
        bus_i.iDC_en   = 1'b1;
        dc_q.push_back('{1'b0, 32'h0});
        cyc();
        cyc();
        chk("pause_b0_addr", s_addr, 32'h400);
        cyc();
        chk("pause_b1_dt", {24'b0, s_dt}, 32'h22);
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("pause_rw%0d", i), {31'b0, s_rw}, 32'd0);
            chk($sformatf("pause_addr%0d", i), s_addr, 32'h402);
        end
        rdy = 1'b1;
        cyc();
        chk("pause_b2_rw", {31'b0, s_rw}, 32'd1);
        chk("pause_b2_dt", {24'b0, s_dt}, 32'h33);
        cyc();
        chk("pause_b3_addr", s_addr, 32'h403);
        chk("pause_b3_dt", {24'b0, s_dt}, 32'h44);
        cyc();
        chk("pause_done", {31'b0, s_ddone}, 32'd1);
        cyc();
        cyc();
        chk("pause_pulses", 32'(dc_pulses - p0), 32'd1);
        chk("pause_wr_count", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            chk($sformatf("pause_wr_addr%0d", i), wlog[i].a, 32'h400 + 32'(i));
            chk($sformatf("pause_wr_dt%0d", i), {24'b0, wlog[i].d}, 32'h11 * 32'(i + 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
